// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter with a run-time shift amount.
// Each accepted start loads the operand and then applies up to STEP bit
// positions per cycle in the latched mode (SLL, SRL, SRA, ROL) until the
// remaining amount reaches zero, at which point a one-cycle done pulse
// is raised. All outputs come straight from registers.
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_mode,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_result
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    M_SLL = 2'b00,
    M_SRL = 2'b01,
    M_SRA = 2'b10,
    M_ROL = 2'b11
  } mode_t;

  // Largest per-cycle step expressed in the shift-amount width.
  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t             r_state;
  state_t             r_state_next;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_next;
  logic [SHAMT_W-1:0] r_rem;
  logic [SHAMT_W-1:0] r_rem_next;
  mode_t              r_mode;
  mode_t              r_mode_next;
  logic               r_done;
  logic               r_done_next;

  logic [SHAMT_W-1:0] w_step;
  logic [SHAMT_W-1:0] w_rem_after;
  logic [WIDTH-1:0]   w_stage [0:SHAMT_W];

  // Amount applied this cycle: the remainder, capped at STEP.
  assign w_step      = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
  assign w_rem_after = r_rem - w_step;

  // Logarithmic barrel: stage gi moves the data by 2**gi when bit gi of
  // the step amount is set. Chaining per-stage SRA keeps the sign, and
  // chaining per-stage rotates yields the full rotate.
  assign w_stage[0] = r_result;

  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int K = 1 << gi;
      logic [WIDTH-1:0] w_moved;

      // Shift the stage input by the constant K in the latched mode.
      always_comb begin
        w_moved = w_stage[gi];
        case (r_mode)
          M_SLL:   w_moved = w_stage[gi] << K;
          M_SRL:   w_moved = w_stage[gi] >> K;
          M_SRA:   w_moved = $signed(w_stage[gi]) >>> K;
          M_ROL:   w_moved = (w_stage[gi] << K) | (w_stage[gi] >> (WIDTH - K));
          default: w_moved = w_stage[gi];
        endcase
      end

      assign w_stage[gi+1] = w_step[gi] ? w_moved : w_stage[gi];
    end
  endgenerate

  // Next-state and next-register values; start is only honoured in IDLE.
  always_comb begin
    r_state_next  = r_state;
    r_result_next = r_result;
    r_rem_next    = r_rem;
    r_mode_next   = r_mode;
    r_done_next   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          r_result_next = i_a;
          r_mode_next   = mode_t'(i_mode);
          r_rem_next    = i_shamt;
          if (i_shamt == '0) begin
            r_done_next = 1'b1;
          end else begin
            r_state_next = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        r_result_next = w_stage[SHAMT_W];
        r_rem_next    = w_rem_after;
        if (w_rem_after == '0) begin
          r_state_next = S_IDLE;
          r_done_next  = 1'b1;
        end
      end
      default: begin
        r_state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_rem    <= '0;
      r_mode   <= M_SLL;
      r_done   <= 1'b0;
    end else begin
      r_state  <= r_state_next;
      r_result <= r_result_next;
      r_rem    <= r_rem_next;
      r_mode   <= r_mode_next;
      r_done   <= r_done_next;
    end
  end

  assign o_busy   = (r_state == S_SHIFT);
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_iter_shifter.sv
// Testbench for iter_shifter: directed and random operations checked
// through a scoreboard of expected results, done cycles and busy lengths.
module tb_iter_shifter;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int STEP    = 4;

  logic               clk;
  logic               i_reset;
  logic               i_start;
  logic [WIDTH-1:0]   i_a;
  logic [SHAMT_W-1:0] i_shamt;
  logic [1:0]         i_mode;
  logic               o_busy;
  logic               o_done;
  logic [WIDTH-1:0]   o_result;

  iter_shifter #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W),
    .STEP   (STEP)
  ) dut (
    .i_clock (clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_a     (i_a),
    .i_shamt (i_shamt),
    .i_mode  (i_mode),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_result(o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
    int          nsteps;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          next_free = 0;
  int          last_k = 0;
  int          last_n = 0;
  int          busy_cnt = 0;
  int          op_id = 0;
  logic [31:0] hold_val = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bit-at-a-time reference shifter.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh, input logic [1:0] md);
    logic [31:0] x;
    x = a;
    for (int i = 0; i < sh; i++) begin
      case (md)
        2'b00:   x = {x[30:0], 1'b0};
        2'b01:   x = {1'b0, x[31:1]};
        2'b10:   x = {x[31], x[31:1]};
        default: x = {x[30:0], x[31]};
      endcase
    end
    return x;
  endfunction

  // Sample DUT outputs just after the edge; cyc equals the edge count.
  task automatic sample();
    exp_t e;
    logic exp_busy;
    cyc++;
    if (i_reset) begin
      check_val("rst_busy", {31'b0, o_busy}, 32'd0);
      check_val("rst_done", {31'b0, o_done}, 32'd0);
      check_val("rst_result", o_result, 32'd0);
      hold_val = '0;
      busy_cnt = 0;
    end else begin
      exp_busy = (cyc >= last_k) && (cyc < last_k + last_n);
      check_val("busy", {31'b0, o_busy}, {31'b0, exp_busy});
      if (o_busy) busy_cnt++;
      if (o_done) begin
        if (sb.size() == 0) begin
          check_val("done_unexpected", {31'b0, o_done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val({e.tag, "_result"}, o_result, e.res);
          check_val({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
          check_val({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'(e.nsteps));
          $display("op %s: result 0x%08h at cycle %0d (busy %0d)", e.tag, o_result, cyc, busy_cnt);
          hold_val = e.res;
          busy_cnt = 0;
        end
      end else if (!o_busy) begin
        check_val("hold", o_result, hold_val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    sample();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drive one start cycle; the bench decides acceptance from its own model.
  task automatic issue(input logic [31:0] a, input int sh, input logic [1:0] md);
    exp_t e;
    int   j;
    int   n;
    i_start = 1'b1;
    i_a     = a;
    i_shamt = SHAMT_W'(sh);
    i_mode  = md;
    j = cyc + 1;
    if (j >= next_free) begin
      n = (sh + STEP - 1) / STEP;
      e.res      = ref_shift(a, sh, md);
      e.done_cyc = j + n;
      e.nsteps   = n;
      e.tag      = $sformatf("op%0d", op_id);
      op_id++;
      sb.push_back(e);
      last_k    = j;
      last_n    = n;
      next_free = (n == 0) ? j + 1 : j + n + 1;
    end
    tick();
    i_start = 1'b0;
  endtask

  task automatic do_reset();
    i_reset   = 1'b1;
    sb.delete();
    last_n    = 0;
    next_free = 0;
    tick();
    i_reset   = 1'b0;
  endtask

  initial begin
    int w;
    i_reset = 1'b1;
    i_start = 1'b0;
    i_a     = '0;
    i_shamt = '0;
    i_mode  = 2'b00;
    tick();
    do_reset();

    issue(32'h0000_0001, 4, 2'b00);
    idle(4);
    issue(32'h8000_0000, 31, 2'b10);
    idle(10);
    issue(32'h8000_0000, 31, 2'b01);
    idle(10);
    issue(32'h8000_0001, 1, 2'b11);
    idle(3);
    issue(32'h1234_5678, 8, 2'b11);
    idle(4);

    for (int m = 0; m < 4; m++) begin
      issue(32'hDEAD_BEEF, 0, 2'(m));
      idle(2);
    end
    issue(32'h0BAD_F00D, 0, 2'b01);
    issue(32'h1357_9BDF, 0, 2'b10);
    idle(2);

    // start held through a busy operation; the done-cycle start is the second op
    issue(32'h0000_000F, 12, 2'b00);
    issue(32'hFFFF_0000, 7, 2'b01);
    issue(32'h5555_AAAA, 3, 2'b10);
    issue(32'h0000_0ABC, 5, 2'b01);
    issue(32'h8000_00F0, 6, 2'b10);
    idle(6);

    // back-to-back with a zero-shift start in the done cycle
    issue(32'h0000_0003, 4, 2'b00);
    idle(1);
    issue(32'hCAFE_0001, 0, 2'b11);
    idle(3);

    // abort mid-operation
    issue(32'h0000_00FF, 20, 2'b00);
    idle(1);
    do_reset();
    idle(8);
    issue(32'hF000_000F, 9, 2'b11);
    idle(5);

    for (int r = 0; r < 25; r++) begin
      issue($urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 3)));
    end

    w = 0;
    while (sb.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    check_val("drain_pending", 32'(sb.size()), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
